// File: rtl/bsh_pipe_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// master = operand source plus result consumer; slave = the shifter itself.
interface bsh_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic [1:0]       mode;
  logic [SHW-1:0]   sh;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, data_in, dir, mode, sh, tag_in, out_ready,
    input  in_ready, out_valid, data_out, tag_out
  );

  modport slave (
    input  in_valid, data_in, dir, mode, sh, tag_in, out_ready,
    output in_ready, out_valid, data_out, tag_out
  );
endinterface

// File: rtl/bsh_pipe.sv
// Fully pipelined barrel shifter: one register per shift level, rotate/logical/
// arithmetic modes, valid/ready flow control with bubble collapsing.
module bsh_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  bsh_pipe_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b10;

  logic [WIDTH-1:0] st_data [SHW];
  logic [TAG_W-1:0] st_tag  [SHW];
  logic [1:0]       st_mode [SHW];
  logic [SHW-1:0]   st_sh   [SHW];
  logic [SHW-1:0]   st_dir;
  logic [SHW-1:0]   st_sgn;
  logic [SHW-1:0]   st_vld;

  logic [WIDTH-1:0] src_data [SHW];
  logic [TAG_W-1:0] src_tag  [SHW];
  logic [1:0]       src_mode [SHW];
  logic [SHW-1:0]   src_sh   [SHW];
  logic [SHW-1:0]   src_dir;
  logic [SHW-1:0]   src_sgn;
  logic [SHW-1:0]   src_vld;

  logic [WIDTH-1:0] nxt_data [SHW];
  logic [SHW-1:0]   nxt_sh   [SHW];
  logic [SHW-1:0]   ld;

  function automatic logic [WIDTH-1:0] shift_lvl(
    input logic [WIDTH-1:0] d,
    input int               s,
    input logic             right,
    input logic [1:0]       md,
    input logic             sgn
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
    case (md)
      MODE_ROT: r = right ? ((d >> s) | (d << (WIDTH - s)))
                          : ((d << s) | (d >> (WIDTH - s)));
      // fill comes from the operand's original sign, carried down the pipe
      MODE_ARI: r = right ? ((d >> s) | fill) : (d << s);
      default:  r = right ? (d >> s) : (d << s);
    endcase
    return r;
  endfunction

  // Load chain: a stage takes new contents when empty or when its successor
  // is taking its current contents; the last stage looks at the consumer.
  always_comb begin
    ld = '0;
    ld[SHW-1] = !st_vld[SHW-1] || bus.out_ready;
    for (int k = SHW - 2; k >= 0; k--) begin
      ld[k] = !st_vld[k] || ld[k+1];
    end
  end

  always_comb begin
    src_data[0] = bus.data_in;
    src_tag[0]  = bus.tag_in;
    src_mode[0] = bus.mode;
    src_sh[0]   = bus.sh;
    src_dir[0]  = bus.dir;
    src_sgn[0]  = bus.data_in[WIDTH-1];
    src_vld[0]  = bus.in_valid;
    for (int k = 1; k < SHW; k++) begin
      src_data[k] = st_data[k-1];
      src_tag[k]  = st_tag[k-1];
      src_mode[k] = st_mode[k-1];
      src_sh[k]   = st_sh[k-1];
      src_dir[k]  = st_dir[k-1];
      src_sgn[k]  = st_sgn[k-1];
      src_vld[k]  = st_vld[k-1];
    end
  end

  // The carried shift amount is consumed LSB-first, so each level only ever
  // looks at bit 0 and passes the rest down one position.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      nxt_data[k] = src_sh[k][0]
                    ? shift_lvl(src_data[k], 1 << k, src_dir[k], src_mode[k], src_sgn[k])
                    : src_data[k];
      nxt_sh[k]   = src_sh[k] >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= '0;
      st_dir <= '0;
      st_sgn <= '0;
      for (int k = 0; k < SHW; k++) begin
        st_data[k] <= '0;
        st_tag[k]  <= '0;
        st_mode[k] <= '0;
        st_sh[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (ld[k]) begin
          st_vld[k]  <= src_vld[k];
          st_dir[k]  <= src_dir[k];
          st_sgn[k]  <= src_sgn[k];
          st_data[k] <= nxt_data[k];
          st_tag[k]  <= src_tag[k];
          st_mode[k] <= src_mode[k];
          st_sh[k]   <= nxt_sh[k];
        end
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = st_vld[SHW-1];
  assign bus.data_out  = st_data[SHW-1];
  assign bus.tag_out   = st_tag[SHW-1];

  // Control fields of the last level have no further consumer.
  logic unused_tail;
  assign unused_tail = ^{st_sh[SHW-1], st_mode[SHW-1], st_dir[SHW-1], st_sgn[SHW-1]};
endmodule
